// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: a single-outstanding request/response pair between
// the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_RDY;
  logic [31:0] IMEM_DATA;

  modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_RDY, input IMEM_DATA);
  modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_RDY, output IMEM_DATA);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory, buffers a
// word across decode stalls and freezes after control transfers until redirected.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] IR_RESET = 32'h0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fetch_stage_if.master        imem,
  input  logic                 V_HAZARD_STALL,
  input  logic                 V_MEM_STALL,
  input  logic                 BR_RESOLVE,
  input  logic                 BR_TAKEN,
  input  logic [63:0]          BR_TARGET,
  input  logic                 TRAP_TAKEN,
  input  logic [63:0]          TRAP_VECTOR,
  output logic [63:0]          DE_NPC,
  output logic [31:0]          DE_IR,
  output logic                 DE_V,
  output logic [1:0]           FE_STATE
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    HOLD       = 2'd1,
    REDIR_WAIT = 2'd2,
    DRAIN      = 2'd3
  } fe_state_t;

  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  function automatic logic is_ecall(input logic [31:0] w);
    return (w & 32'h0FFF_FFFF) == 32'h0000_0073;
  endfunction

  function automatic logic is_ctrl(input logic [31:0] w);
    logic [31:0] op;
    op = w & 32'h0000_007F;
    return (op == 32'h0000_0063) || (op == 32'h0000_006F) ||
           (op == 32'h0000_0067) || is_ecall(w);
  endfunction

  fe_state_t   r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [63:0] r_addr, w_addr_nxt;
  logic        r_req, w_req_nxt;
  logic [63:0] r_de_npc, w_de_npc_nxt;
  logic [31:0] r_de_ir, w_de_ir_nxt;
  logic        r_de_v, w_de_v_nxt;
  logic [31:0] r_hold_ir, w_hold_ir_nxt;
  logic [63:0] r_hold_npc, w_hold_npc_nxt;
  logic        r_hold_v, w_hold_v_nxt;
  logic        r_ecall, w_ecall_nxt;

  logic        w_ld_de;
  logic        w_accept;
  logic        w_waiting;
  logic        w_br_redir;
  logic [63:0] w_pc_inc;

  assign w_ld_de   = !V_HAZARD_STALL && !V_MEM_STALL;
  assign w_accept  = r_req && imem.IMEM_RDY;
  assign w_waiting = r_req && !imem.IMEM_RDY;
  assign w_pc_inc  = r_pc + 64'd4;
  // While frozen any resolve releases fetch (except behind an ECALL); otherwise only taken ones redirect.
  assign w_br_redir = BR_RESOLVE && ((r_state == REDIR_WAIT) ? !r_ecall : BR_TAKEN);

  // Next-state, PC, DE latch and hold-buffer computation.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_de_npc_nxt   = r_de_npc;
    w_de_ir_nxt    = r_de_ir;
    w_de_v_nxt     = r_de_v;
    w_hold_ir_nxt  = r_hold_ir;
    w_hold_npc_nxt = r_hold_npc;
    w_hold_v_nxt   = r_hold_v;
    w_ecall_nxt    = r_ecall;

    if (TRAP_TAKEN) begin
      w_pc_nxt     = TRAP_VECTOR & ALIGN_MASK;
      w_de_v_nxt   = 1'b0;
      w_de_ir_nxt  = IR_RESET;
      w_hold_v_nxt = 1'b0;
      w_ecall_nxt  = 1'b0;
      w_state_nxt  = w_waiting ? DRAIN : FETCH;
    end else if (w_br_redir) begin
      if (r_state == REDIR_WAIT) begin
        w_pc_nxt = BR_TAKEN ? (BR_TARGET & ALIGN_MASK) : r_pc;
      end else begin
        w_pc_nxt = BR_TARGET & ALIGN_MASK;
      end
      w_hold_v_nxt = 1'b0;
      w_ecall_nxt  = 1'b0;
      w_state_nxt  = w_waiting ? DRAIN : FETCH;
      if (w_ld_de) begin
        w_de_v_nxt = 1'b0;
      end else begin
        w_de_v_nxt = r_de_v;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_accept) begin
            w_pc_nxt = w_pc_inc;
            if (w_ld_de) begin
              w_de_ir_nxt  = imem.IMEM_DATA;
              w_de_npc_nxt = w_pc_inc;
              w_de_v_nxt   = 1'b1;
              w_ecall_nxt  = is_ecall(imem.IMEM_DATA);
              w_state_nxt  = is_ctrl(imem.IMEM_DATA) ? REDIR_WAIT : FETCH;
            end else begin
              w_hold_ir_nxt  = imem.IMEM_DATA;
              w_hold_npc_nxt = w_pc_inc;
              w_hold_v_nxt   = 1'b1;
              w_state_nxt    = HOLD;
            end
          end else if (w_ld_de) begin
            w_de_v_nxt = 1'b0;
          end else begin
            w_de_v_nxt = r_de_v;
          end
        end
        HOLD: begin
          if (w_ld_de) begin
            w_de_ir_nxt  = r_hold_ir;
            w_de_npc_nxt = r_hold_npc;
            w_de_v_nxt   = 1'b1;
            w_hold_v_nxt = 1'b0;
            w_ecall_nxt  = is_ecall(r_hold_ir);
            w_state_nxt  = is_ctrl(r_hold_ir) ? REDIR_WAIT : FETCH;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        REDIR_WAIT: begin
          if (w_ld_de) begin
            w_de_v_nxt = 1'b0;
          end else begin
            w_de_v_nxt = r_de_v;
          end
        end
        DRAIN: begin
          if (imem.IMEM_RDY) begin
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = DRAIN;
          end
          if (w_ld_de) begin
            w_de_v_nxt = 1'b0;
          end else begin
            w_de_v_nxt = r_de_v;
          end
        end
        default: begin
          w_state_nxt = FETCH;
        end
      endcase
    end

    // DRAIN keeps presenting the abandoned address until its response returns.
    w_req_nxt  = (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
    w_addr_nxt = (w_state_nxt == DRAIN) ? r_addr : (w_pc_nxt & ALIGN_MASK);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC & ALIGN_MASK;
      r_req      <= 1'b0;
      r_de_npc   <= 64'h0;
      r_de_ir    <= IR_RESET;
      r_de_v     <= 1'b0;
      r_hold_ir  <= 32'h0;
      r_hold_npc <= 64'h0;
      r_hold_v   <= 1'b0;
      r_ecall    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
      r_de_npc   <= w_de_npc_nxt;
      r_de_ir    <= w_de_ir_nxt;
      r_de_v     <= w_de_v_nxt;
      r_hold_ir  <= w_hold_ir_nxt;
      r_hold_npc <= w_hold_npc_nxt;
      r_hold_v   <= w_hold_v_nxt;
      r_ecall    <= w_ecall_nxt;
    end
  end

  assign imem.IMEM_REQ  = r_req;
  assign imem.IMEM_ADDR = r_addr;
  assign DE_NPC         = r_de_npc;
  assign DE_IR          = r_de_ir;
  assign DE_V           = r_de_v;
  assign FE_STATE       = r_state;

endmodule
